// File: rtl/fib_seq_engine.sv
// Fibonacci engine with its datapath and control in one block. It computes F(N) either as a
// single result or as a stream of every term F(0)..F(N) on a valid/ready port.
module fib_seq_engine #(
   parameter int WIDTH = 16,
   parameter int NW    = 6
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic             ABORT,
   input  logic [NW-1:0]    N,
   input  logic             MODE,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] RESULT,
   output logic             OVF,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic [WIDTH-1:0] OUT_DATA,
   output logic [NW-1:0]    OUT_IDX
);

   typedef enum logic [1:0] {IDLE, CALC, EMIT} state_t;

   state_t           state;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             aOvf;
   logic             bOvf;
   logic [NW-1:0]    idx;
   logic [NW-1:0]    nQ;
   logic [WIDTH:0]   sum;
   logic             atEnd;
   logic             accept;
   logic             advance;

   assign sum    = {1'b0, a} + {1'b0, b};
   assign atEnd  = (idx == nQ);
   assign accept = (state == IDLE) && START && !ABORT;
   // A step happens in CALC every cycle and in EMIT only on a handshake; the last term never steps.
   assign advance = !ABORT && !atEnd &&
                    ((state == CALC) || ((state == EMIT) && OUT_READY));

   assign BUSY      = (state != IDLE);
   assign OVF       = aOvf;
   assign OUT_VALID = (state == EMIT);
   assign OUT_DATA  = a;
   assign OUT_IDX   = idx;

   // Term pair a=F(idx), b=F(idx+1); the overflow flags are sticky, so they ride along with the terms.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         a    <= '0;
         b    <= '0;
         aOvf <= 1'b0;
         bOvf <= 1'b0;
         idx  <= '0;
         nQ   <= '0;
      end else if (accept) begin
         nQ   <= N;
         a    <= '0;
         b    <= {{(WIDTH-1){1'b0}}, 1'b1};
         aOvf <= 1'b0;
         bOvf <= 1'b0;
         idx  <= '0;
      end else if (advance) begin
         a    <= b;
         aOvf <= bOvf;
         b    <= sum[WIDTH-1:0];
         bOvf <= bOvf | sum[WIDTH];
         idx  <= idx + 1'b1;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state  <= IDLE;
         DONE   <= 1'b0;
         RESULT <= '0;
      end else begin
         DONE <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) state <= MODE ? EMIT : CALC;
            end
            CALC: begin
               if (ABORT) begin
                  state <= IDLE;
               end else if (atEnd) begin
                  RESULT <= a;
                  DONE   <= 1'b1;
                  state  <= IDLE;
               end
            end
            EMIT: begin
               if (ABORT) begin
                  state <= IDLE;
               end else if (OUT_READY && atEnd) begin
                  RESULT <= a;
                  DONE   <= 1'b1;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fib_seq_engine.sv
// Bench for fib_seq_engine: a table of runs issued back to back, plus hand-written abort, reset
// and stray-start sequences. Beats and results are checked from scoreboard queues.
module tb_fib_seq_engine;

   localparam int WIDTH = 16;
   localparam int NW    = 6;

   typedef struct {
      logic [WIDTH-1:0] data;
      logic [NW-1:0]    idx;
      logic             ovf;
   } beat_t;

   typedef struct {
      logic [WIDTH-1:0] res;
      logic             ovf;
   } res_t;

   typedef struct {
      logic             mode;
      int               n;
      logic [WIDTH-1:0] expRes;
      logic             expOvf;
   } vec_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic             abort = 1'b0;
   logic             mode = 1'b0;
   logic [NW-1:0]    n = '0;
   logic             outReady = 1'b0;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             ovf;
   logic             outValid;
   logic [WIDTH-1:0] outData;
   logic [NW-1:0]    outIdx;

   int    nChecks = 0;
   int    nPass = 0;
   bit    readyRandom = 1'b1;
   beat_t beatQ[$];
   res_t  resQ[$];
   vec_t  vecs[10];

   fib_seq_engine #(.WIDTH(WIDTH), .NW(NW)) dut (
      .CLK(clk), .RST(rst), .START(start), .ABORT(abort), .N(n), .MODE(mode),
      .BUSY(busy), .DONE(done), .RESULT(result), .OVF(ovf),
      .OUT_VALID(outValid), .OUT_READY(outReady), .OUT_DATA(outData), .OUT_IDX(outIdx)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      nChecks++;
      if (act === exp) nPass++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // True Fibonacci value in 64 bits; the DUT view is its low WIDTH bits plus "exceeded WIDTH".
   function automatic longint unsigned fib(input int k);
      longint unsigned x = 0, y = 1, t;
      for (int i = 0; i < k; i++) begin
         t = x + y;
         x = y;
         y = t;
      end
      return x;
   endfunction

   task automatic pushBeats(input int nn);
      longint unsigned f;
      beat_t bt;
      for (int i = 0; i <= nn; i++) begin
         f       = fib(i);
         bt.data = f[WIDTH-1:0];
         bt.idx  = i[NW-1:0];
         bt.ovf  = (f > 64'd65535);
         beatQ.push_back(bt);
      end
   endtask

   task automatic driveStart(input logic m, input int nn);
      start = 1'b1;
      mode  = m;
      n     = nn[NW-1:0];
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      checkOutput("busy after accept", busy, 1);
      checkOutput("done low after accept", done, 0);
   endtask

   task automatic applyStimulus(input logic m, input int nn, input logic [WIDTH-1:0] expRes,
                                input logic expOvf);
      res_t r;
      r.res = expRes;
      r.ovf = expOvf;
      resQ.push_back(r);
      if (m) pushBeats(nn);
      driveStart(m, nn);
   endtask

   // Returns at the negedge where DONE is seen, so the caller can start the next run in that cycle.
   task automatic waitDone(input int nn, input bit checkTiming);
      int cycles = 0;
      int busyCnt = 0;
      while (!done && cycles < 5000) begin
         if (busy) busyCnt++;
         cycles++;
         @(negedge clk);
      end
      checkOutput("done seen", done, 1);
      checkOutput("beats left at done", beatQ.size(), 0);
      if (checkTiming) begin
         checkOutput("done latency", cycles, nn + 1);
         checkOutput("busy cycles", busyCnt, nn + 1);
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, " busy"}, busy, 0);
      checkOutput({tag, " done"}, done, 0);
      checkOutput({tag, " ovf"}, ovf, 0);
      checkOutput({tag, " out_valid"}, outValid, 0);
      checkOutput({tag, " result"}, result, 0);
      checkOutput({tag, " out_data"}, outData, 0);
      checkOutput({tag, " out_idx"}, outIdx, 0);
   endtask

   // Scoreboard side: compare each offered beat and each DONE, then choose READY for the next edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (outValid) begin
            if (beatQ.size() == 0) begin
               checkOutput("unexpected beat", outIdx, 64'hFFFF);
            end else begin
               checkOutput("beat data", outData, beatQ[0].data);
               checkOutput("beat idx", outIdx, beatQ[0].idx);
               checkOutput("beat ovf", ovf, beatQ[0].ovf);
            end
         end
         if (done) begin
            if (resQ.size() == 0) begin
               checkOutput("unexpected done", done, 0);
            end else begin
               checkOutput("result", result, resQ[0].res);
               checkOutput("ovf at done", ovf, resQ[0].ovf);
               void'(resQ.pop_front());
            end
         end
         outReady = readyRandom ? ($urandom_range(0, 1) == 1) : 1'b1;
         if (outValid && outReady && beatQ.size() > 0) void'(beatQ.pop_front());
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got timeout, expected finish");
      $fatal(1);
   end

   initial begin
      logic [WIDTH-1:0] prevRes;
      int k;

      vecs[0] = '{1'b0, 10, 16'd55, 1'b0};
      vecs[1] = '{1'b0, 0, 16'd0, 1'b0};
      vecs[2] = '{1'b0, 1, 16'd1, 1'b0};
      vecs[3] = '{1'b0, 2, 16'd1, 1'b0};
      vecs[4] = '{1'b1, 7, 16'd13, 1'b0};
      vecs[5] = '{1'b0, 24, 16'd46368, 1'b0};
      vecs[6] = '{1'b0, 25, 16'd9489, 1'b1};
      vecs[7] = '{1'b1, 25, 16'd9489, 1'b1};
      vecs[8] = '{1'b1, 0, 16'd0, 1'b0};
      vecs[9] = '{1'b0, 30, 16'd45608, 1'b1};

      #12;
      checkAllZero("reset");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 10; i++) begin
         applyStimulus(vecs[i].mode, vecs[i].n, vecs[i].expRes, vecs[i].expOvf);
         waitDone(vecs[i].n, !vecs[i].mode);
      end

      // Abort on stream beat 3 with a stray START alongside; nothing must complete.
      @(negedge clk);
      readyRandom = 1'b0;
      prevRes = result;
      pushBeats(7);
      driveStart(1'b1, 7);
      k = 0;
      while (!(outValid && outIdx == 3) && k < 50) begin
         @(negedge clk);
         k++;
      end
      checkOutput("reached beat 3", outIdx, 3);
      abort = 1'b1;
      start = 1'b1;
      n     = 6'd2;
      @(posedge clk);
      @(negedge clk);
      abort = 1'b0;
      start = 1'b0;
      checkOutput("abort busy", busy, 0);
      checkOutput("abort out_valid", outValid, 0);
      checkOutput("abort done", done, 0);
      checkOutput("abort result kept", result, prevRes);
      beatQ.delete();
      repeat (3) @(negedge clk);
      checkOutput("idle after abort", busy, 0);
      readyRandom = 1'b1;

      // ABORT beats START in IDLE.
      start = 1'b1;
      abort = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      checkOutput("abort blocks start", busy, 0);

      // START while busy is ignored: a switch to stream mode with N=3 must not take effect.
      applyStimulus(1'b0, 10, 16'd55, 1'b0);
      repeat (3) @(negedge clk);
      start = 1'b1;
      mode  = 1'b1;
      n     = 6'd3;
      @(negedge clk);
      start = 1'b0;
      waitDone(10, 1'b0);

      // Asynchronous reset in the middle of a long single run.
      @(negedge clk);
      driveStart(1'b0, 20);
      repeat (5) @(negedge clk);
      #1 rst = 1'b1;
      #1 checkAllZero("mid-run reset");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      applyStimulus(1'b0, 5, 16'd5, 1'b0);
      waitDone(5, 1'b1);

      repeat (3) @(negedge clk);
      checkOutput("beat queue drained", beatQ.size(), 0);
      checkOutput("result queue drained", resQ.size(), 0);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
